data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Multi-cycle data-memory responder serving the MEM pipeline stage: accepts one load or store request at a time, holds the pipeline with `stall` for a fixed access latency, then completes with a one-cycle `done` pulse and read data. It replaces the single-cycle data memory behind the MEM stage, so the pipeline sees realistic memory latency. Squashed requests (taken branch in flight) are cancelled via `req_kill`.

## Interface
Parameters:
- `DEPTH_LOG2`, 10: backing array holds 2^DEPTH_LOG2 16-bit words.
- `LATENCY`, 4: cycles from accept to `done`; legal range 1..15.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-low reset (asserted when 0).
- `req_en`  in  1  request valid; requester holds all `req_*` stable while `stall`=1.
- `req_wr`  in  1  1 = store, 0 = load.
- `req_addr`  in  16  byte address; word index = `req_addr[DEPTH_LOG2:1]`.
- `req_data`  in  16  store data.
- `req_kill`  in  1  cancel the in-flight request.
- `stall`  out  1  combinational: `req_en` & (state != RESP).
- `done`  out  1  one-cycle completion pulse.
- `rsp_data`  out  16  load data; valid with `done`, held until next `done`.
- `err`  out  1  misaligned access flag; valid with `done`.
- `busy`  out  1  state != IDLE.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: `req_en`=1 and `req_kill`=0 is an accept. Latch wr/addr/data, compute misalignment (`req_addr[0]`). Next state is RESP if LATENCY=1, else WAIT with `cnt` = LATENCY-2.
- WAIT: `req_kill`=1 returns to IDLE next cycle with no `done`, no write, and outputs unchanged. Otherwise `cnt`=0 goes to RESP, else decrement `cnt`.
- RESP: `done`=1.
  - Aligned store: array written at the clock edge ending RESP; `rsp_data` = 0x0000.
  - Aligned load: `rsp_data` = array word.
  - Misaligned: `err`=1, no array access, `rsp_data` = 0x0000.
  - Next state is always IDLE. `req_kill` is ignored in RESP; the request is already committed.
- `stall` drops in RESP, so the requester advances at that edge. The request present in RESP is consumed and is not re-accepted.
- `err` and `done` are registered with RESP; `err` clears the cycle after.
- Reset (`rst`=0): state IDLE, `cnt`=0, `done`=0, `err`=0, `rsp_data`=0x0000, `busy`=0. Array contents are not reset. Reset mid-transaction aborts it, and a pending store is discarded.
- `req_addr` bits above DEPTH_LOG2 are ignored (address wraps modulo array size).

## Timing
- Accept at cycle T → `done` at cycle T+LATENCY, exactly one cycle wide.
- `stall`=1 for cycles T..T+LATENCY-1 while `req_en`=1; `stall`=0 at T+LATENCY.
- Back-to-back: next accept earliest at T+LATENCY+1 (one IDLE cycle). Sustained throughput is one request per LATENCY+1 cycles.
- Store at RESP cycle R is visible to a load accepted at R+1 or later.
- `stall` is combinational from `req_en`. There is no combinational path from `req_addr`/`req_data` to any output.

## Structure
- Shared package `dmem_pkg`:
  - state encoding enum (IDLE=2'd0, WAIT=2'd1, RESP=2'd2)
  - default LATENCY and DEPTH_LOG2 constants
  - `cnt` width constant (4)
- Sub-module `dmem_array`: single-port array of 2^DEPTH_LOG2 × 16, synchronous write when `we`, combinational read. No reset.
- Top level holds the FSM, counter, request latches and output registers.

## Test plan
- Store 0xBEEF to 0x0010, then load 0x0010 (LATENCY=4) → `done` 4 cycles after each accept; load `rsp_data`=0xBEEF, `err`=0.
- Load from misaligned 0x0011 → `done` at T+4 with `err`=1 and `rsp_data`=0x0000; the word at 0x0010 is unchanged on reload.
- Store 0x1234 to 0x0020, assert `req_kill` at T+2 → no `done`, `busy`=0 at T+3; a later load of 0x0020 returns the old value.
- Two back-to-back loads (0x0002, 0x0004) with `req_en` held → `done` at T+4 and T+9; `stall` low only in the `done` cycles.
- Assert `rst`=0 during WAIT of a store to 0x0030 → next cycle all outputs are 0 and state is IDLE; a later load of 0x0030 shows no write.
- LATENCY=1: load accepted at T → `done` at T+1; `stall` high only at T.

Source files
------------

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data-memory responder
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmemState_e;

    localparam int DEFAULT_LATENCY    = 4;
    localparam int DEFAULT_DEPTH_LOG2 = 10;
    localparam int CNT_W              = 4;

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - single-port 16-bit word array, synchronous write, combinational read
import dmem_pkg::*;

module dmem_array #(
    parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [15:0]           wdata,
    output logic [15:0]           rdata
);

    logic [15:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - multi-cycle load/store responder for the MEM stage
import dmem_pkg::*;

module data_mem_responder #(
    parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2,
    parameter int LATENCY    = DEFAULT_LATENCY
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_en,
    input  logic        req_wr,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_data,
    input  logic        req_kill,
    output logic        stall,
    output logic        done,
    output logic [15:0] rsp_data,
    output logic        err,
    output logic        busy
);

    dmemState_e            state, nextState;
    logic [CNT_W-1:0]      cnt, nextCnt;
    logic                  wrLatch, misLatch;
    logic [DEPTH_LOG2-1:0] idxLatch;
    logic [15:0]           dataLatch;

    logic                  accept;
    logic                  curWr, curMis;
    logic [DEPTH_LOG2-1:0] arrIdx;
    logic [15:0]           arrData;
    logic                  arrWe;
    logic                  unusedAddr;

    assign accept = (state == IDLE) && req_en && !req_kill;

    // With LATENCY=1 the edge entering RESP is the accept edge, so the live
    // request fields are used there instead of the not-yet-loaded latches.
    assign curWr  = (state == IDLE) ? req_wr   : wrLatch;
    assign curMis = (state == IDLE) ? req_addr[0] : misLatch;
    assign arrIdx = (state == IDLE) ? req_addr[DEPTH_LOG2:1] : idxLatch;

    assign arrWe = rst && (state == RESP) && wrLatch && !misLatch;

    assign unusedAddr = ^req_addr;

    dmem_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
        .clk   (clk),
        .we    (arrWe),
        .addr  (arrIdx),
        .wdata (dataLatch),
        .rdata (arrData)
    );

    always_comb begin
        nextState = state;
        nextCnt   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        nextState = RESP;
                    end else begin
                        nextState = WAIT;
                        nextCnt   = CNT_W'(LATENCY - 2);
                    end
                end
            end
            WAIT: begin
                if (req_kill) begin
                    nextState = IDLE;
                end else if (cnt == '0) begin
                    nextState = RESP;
                end else begin
                    nextCnt = cnt - 1'b1;
                end
            end
            RESP:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            rsp_data <= 16'h0000;
        end else begin
            state <= nextState;
            cnt   <= nextCnt;
            done  <= (nextState == RESP);
            err   <= (nextState == RESP) && curMis;
            if (nextState == RESP) begin
                rsp_data <= (curWr || curMis) ? 16'h0000 : arrData;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            wrLatch   <= req_wr;
            misLatch  <= req_addr[0];
            idxLatch  <= req_addr[DEPTH_LOG2:1];
            dataLatch <= req_data;
        end
    end

    assign stall = req_en && (state != RESP);
    assign busy  = (state != IDLE);

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - scoreboard bench for data_mem_responder
module tb_data_mem_responder;

    typedef struct {
        logic [15:0] data;
        logic        err;
        int          cyc;
    } expItem_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;

    logic        en0 = 0, wr0 = 0, kill0 = 0;
    logic [15:0] addr0 = 0, data0 = 0;
    logic        stall0, done0, err0, busy0;
    logic [15:0] rsp0;

    logic        en1 = 0, wr1 = 0, kill1 = 0;
    logic [15:0] addr1 = 0, data1 = 0;
    logic        stall1, done1, err1, busy1;
    logic [15:0] rsp1;

    expItem_t q0[$];
    expItem_t q1[$];

    int passCnt  = 0;
    int totalCnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_responder #(.DEPTH_LOG2(10), .LATENCY(4)) dut0 (
        .clk(clk), .rst(rst), .req_en(en0), .req_wr(wr0), .req_addr(addr0),
        .req_data(data0), .req_kill(kill0), .stall(stall0), .done(done0),
        .rsp_data(rsp0), .err(err0), .busy(busy0)
    );

    data_mem_responder #(.DEPTH_LOG2(10), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .req_en(en1), .req_wr(wr1), .req_addr(addr1),
        .req_data(data1), .req_kill(kill1), .stall(stall1), .done(done1),
        .rsp_data(rsp1), .err(err1), .busy(busy1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every done pulse must match the oldest expected response.
    always @(negedge clk) begin
        expItem_t e;
        if (rst && done0) begin
            if (q0.size() == 0) chk("dut0 unexpected done", 1, 0);
            else begin
                e = q0.pop_front();
                chk("dut0 rsp_data", {16'h0, rsp0}, {16'h0, e.data});
                chk("dut0 err", {31'h0, err0}, {31'h0, e.err});
                chk("dut0 done cycle", cyc, e.cyc);
            end
        end
        if (rst && done1) begin
            if (q1.size() == 0) chk("dut1 unexpected done", 1, 0);
            else begin
                e = q1.pop_front();
                chk("dut1 rsp_data", {16'h0, rsp1}, {16'h0, e.data});
                chk("dut1 err", {31'h0, err1}, {31'h0, e.err});
                chk("dut1 done cycle", cyc, e.cyc);
            end
        end
    end

    task automatic doReq(input int which, input logic wr, input logic [15:0] addr,
                         input logic [15:0] data, input logic [15:0] expData, input logic expErr);
        int lat;
        int stallCycles;
        bit seenLow;
        expItem_t e;
        lat = (which == 0) ? 4 : 1;
        @(posedge clk); #1;
        if (which == 0) begin en0 = 1; wr0 = wr; addr0 = addr; data0 = data; end
        else            begin en1 = 1; wr1 = wr; addr1 = addr; data1 = data; end
        e.data = expData; e.err = expErr; e.cyc = cyc + lat;
        if (which == 0) q0.push_back(e); else q1.push_back(e);
        stallCycles = 0;
        seenLow = 0;
        for (int i = 0; i < 30 && !seenLow; i++) begin
            @(negedge clk);
            if (((which == 0) ? stall0 : stall1) == 1'b1) stallCycles++;
            else seenLow = 1;
        end
        chk("stall released", {31'h0, seenLow}, 1);
        chk("stall high cycles", stallCycles, lat);
    endtask

    task automatic idle();
        @(posedge clk); #1;
        en0 = 0; en1 = 0; kill0 = 0; kill1 = 0;
    endtask

    initial begin
        int t;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset done", {31'h0, done0}, 0);
        chk("reset err", {31'h0, err0}, 0);
        chk("reset rsp_data", {16'h0, rsp0}, 0);
        chk("reset busy", {31'h0, busy0}, 0);
        chk("reset busy dut1", {31'h0, busy1}, 0);
        @(posedge clk); #1 rst = 1;

        doReq(0, 1, 16'h0020, 16'h5555, 16'h0000, 0); idle();
        doReq(0, 1, 16'h0030, 16'h7777, 16'h0000, 0); idle();
        doReq(0, 1, 16'h0002, 16'h1111, 16'h0000, 0); idle();
        doReq(0, 1, 16'h0004, 16'h2222, 16'h0000, 0); idle();

        doReq(0, 1, 16'h0010, 16'hBEEF, 16'h0000, 0); idle();
        doReq(0, 0, 16'h0010, 16'h0000, 16'hBEEF, 0); idle();
        doReq(0, 0, 16'h0011, 16'h0000, 16'h0000, 1); idle();
        doReq(0, 1, 16'h0013, 16'hDEAD, 16'h0000, 1); idle();
        doReq(0, 0, 16'h0010, 16'h0000, 16'hBEEF, 0); idle();
        // High address bits wrap onto word 0x0010.
        doReq(0, 0, 16'h8010, 16'h0000, 16'hBEEF, 0); idle();

        // Killed store: no done, idle one cycle after the kill.
        @(posedge clk); #1;
        en0 = 1; wr0 = 1; addr0 = 16'h0020; data0 = 16'h1234;
        t = cyc;
        @(posedge clk); #1;
        @(posedge clk); #1 kill0 = 1;
        chk("kill timing", cyc, t + 2);
        @(posedge clk); #1 kill0 = 0; en0 = 0;
        @(negedge clk);
        chk("busy after kill", {31'h0, busy0}, 0);
        chk("done after kill", {31'h0, done0}, 0);
        doReq(0, 0, 16'h0020, 16'h0000, 16'h5555, 0); idle();

        // Reset during the wait of a store.
        @(posedge clk); #1;
        en0 = 1; wr0 = 1; addr0 = 16'h0030; data0 = 16'hAAAA;
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 0;
        @(posedge clk); #1 rst = 1; en0 = 0;
        @(negedge clk);
        chk("rst mid rsp_data", {16'h0, rsp0}, 0);
        chk("rst mid err", {31'h0, err0}, 0);
        chk("rst mid done", {31'h0, done0}, 0);
        chk("rst mid busy", {31'h0, busy0}, 0);
        chk("rst mid stall", {31'h0, stall0}, 0);
        doReq(0, 0, 16'h0030, 16'h0000, 16'h7777, 0); idle();

        // Back-to-back loads with req_en held.
        doReq(0, 0, 16'h0002, 16'h0000, 16'h1111, 0);
        doReq(0, 0, 16'h0004, 16'h0000, 16'h2222, 0);
        idle();

        // Single-cycle latency instance.
        doReq(1, 1, 16'h0040, 16'hCAFE, 16'h0000, 0);
        doReq(1, 0, 16'h0040, 16'h0000, 16'hCAFE, 0);
        doReq(1, 0, 16'h0041, 16'h0000, 16'h0000, 1);
        idle();

        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("dut0 queue drained", q0.size(), 0);
        chk("dut1 queue drained", q1.size(), 0);
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
